servo_pwm_array: RTL and testbench

- N-channel hobby-servo PWM generator.
- Parametrised successor to the fixed two-servo PWM stage in the line-follower top level.
- Accepts a packed vector of per-channel position commands over a valid/ready handshake and double-buffers it in a shadow register.
- Commits new positions only at frame boundaries, so no pulse is ever truncated or stretched mid-frame.
- Sits between the servo handler / PID path and the servo pins, on the 100 MHz system clock.

---
 rtl/servo_pkg.sv | 29 ++
 rtl/us_tick_gen.sv | 25 ++
 rtl/servo_pwm_array.sv | 120 ++++++++++++
 tb/tb_servo_pwm_array.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared timing defaults and helpers for the servo PWM block: the command-to-pulse
// mapping and the microsecond counter width.
package servo_pkg;

  localparam int DEF_CLK_HZ   = 100_000_000;
  localparam int DEF_FRAME_US = 20_000;
  localparam int DEF_MIN_US   = 1000;
  localparam int DEF_MAX_US   = 2000;

  function automatic int centre_us(input int min_us, input int max_us);
    return (min_us + max_us) / 2;
  endfunction

  // Counter width for a frame of frame_us microseconds; also holds any pulse width.
  function automatic int us_width(input int frame_us);
    return $clog2(frame_us);
  endfunction

  // 64-bit product so cmd*(max-min) cannot overflow for any sane CMD_W.
  function automatic int cmd_to_us(input logic [31:0] cmd, input int cmd_w,
                                   input int min_us, input int max_us);
    logic [63:0] prod;
    logic [63:0] full;
    prod = 64'(cmd) * 64'(max_us - min_us);
    full = (64'd1 << cmd_w) - 64'd1;
    return min_us + int'(prod / full);
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; cleared and held while
// hold is high so the frame restarts from a clean microsecond.
module us_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  assign tick = !hold && (pre == LAST);

  always_ff @(posedge clk) begin
    if (rst || hold)  pre <= '0;
    else if (tick)    pre <= '0;
    else              pre <= pre + 1'b1;
  end

endmodule

// File: rtl/servo_pwm_array.sv
// N-channel servo PWM with a double-buffered command set committed at frame boundaries.
// Define SERVO_SLEW_EN to ramp each width toward its target by at most SLEW_US per frame.
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CMD_W    = 8,
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int FRAME_US = DEF_FRAME_US,
  parameter int MIN_US   = DEF_MIN_US,
  parameter int MAX_US   = DEF_MAX_US,
  parameter int SLEW_US  = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CHANNELS*CMD_W-1:0] cmd,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      frame_start
);

  if (MIN_US >= MAX_US) begin : g_chk_range
    $error("servo_pwm_array: MIN_US must be below MAX_US");
  end
  if (MAX_US >= FRAME_US) begin : g_chk_frame
    $error("servo_pwm_array: MAX_US must be below FRAME_US");
  end
  if ((CLK_HZ % 1_000_000) != 0) begin : g_chk_clk
    $error("servo_pwm_array: CLK_HZ must be a multiple of 1 MHz");
  end
  if (SLEW_US < 1) begin : g_chk_slew
    $error("servo_pwm_array: SLEW_US must be positive");
  end

  localparam int TICK_DIV = CLK_HZ / 1_000_000;
  localparam int W        = us_width(FRAME_US);

  typedef logic [W-1:0] us_t;

  localparam us_t CENTRE  = us_t'(centre_us(MIN_US, MAX_US));
  localparam us_t LAST_US = us_t'(FRAME_US - 1);

  logic                     tick;
  logic                     boundary;
  logic                     accept;
  logic                     commit;
  logic                     pending;
  us_t                      us_cnt;
  logic [CHANNELS-1:0][W-1:0] mapped;
  logic [CHANNELS-1:0][W-1:0] shadow;
  logic [CHANNELS-1:0][W-1:0] active;

  us_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .hold (!enable),
    .tick (tick)
  );

  assign boundary  = tick && (us_cnt == LAST_US);
  assign cmd_ready = !pending;
  assign accept    = cmd_valid && cmd_ready;
  assign commit    = boundary && pending;

  // Mapping happens on the way into the shadow so the output path only compares.
  always_comb begin
    mapped = '0;
    for (int i = 0; i < CHANNELS; i++)
      mapped[i] = us_t'(cmd_to_us(32'(cmd[i*CMD_W +: CMD_W]), CMD_W, MIN_US, MAX_US));
  end

`ifdef SERVO_SLEW_EN
  localparam us_t SLEW = us_t'(SLEW_US);

  logic [CHANNELS-1:0][W-1:0] target;

  function automatic us_t slew_step(input us_t cur, input us_t goal);
    if (goal > cur) return ((goal - cur) > SLEW) ? cur + SLEW : goal;
    else            return ((cur - goal) > SLEW) ? cur - SLEW : goal;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      pwm         <= '0;
      shadow      <= {CHANNELS{CENTRE}};
      active      <= {CHANNELS{CENTRE}};
`ifdef SERVO_SLEW_EN
      target      <= {CHANNELS{CENTRE}};
`endif
    end else begin
      frame_start <= boundary;
      if (!enable)   us_cnt <= '0;
      else if (tick) us_cnt <= boundary ? '0 : us_cnt + 1'b1;

      // Accept cannot coincide with commit: ready is low whenever pending is set.
      if (commit)      pending <= 1'b0;
      else if (accept) pending <= 1'b1;
      if (accept) shadow <= mapped;

`ifdef SERVO_SLEW_EN
      if (commit) target <= shadow;
      if (boundary)
        for (int i = 0; i < CHANNELS; i++)
          active[i] <= slew_step(active[i], commit ? shadow[i] : target[i]);
`else
      if (commit) active <= shadow;
`endif

      for (int i = 0; i < CHANNELS; i++)
        pwm[i] <= enable && (us_cnt < active[i]);
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Randomised bench for servo_pwm_array: a frame-level model predicts each pulse width
// in cycles, frame period and handshake state.
module tb_servo_pwm_array;

  localparam int CH        = 2;
  localparam int CW        = 8;
  localparam int CLK_HZ    = 2_000_000;
  localparam int FRAME_US  = 3000;
  localparam int MIN_US    = 1000;
  localparam int MAX_US    = 2000;
  localparam int SLEW_US   = 50;
  localparam int TDIV      = CLK_HZ / 1_000_000;
  localparam int FRAME_CYC = FRAME_US * TDIV;
  localparam int CENTRE    = (MIN_US + MAX_US) / 2;
`ifdef SERVO_SLEW_EN
  localparam bit SLEW = 1'b1;
  localparam int RAMP = 11;
`else
  localparam bit SLEW = 1'b0;
  localparam int RAMP = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [CH*CW-1:0] cmd;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH-1:0]    pwm;
  logic             frame_start;

  always #5 clk = ~clk;

  servo_pwm_array #(
    .CHANNELS(CH), .CMD_W(CW), .CLK_HZ(CLK_HZ), .FRAME_US(FRAME_US),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .SLEW_US(SLEW_US)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .pwm(pwm), .frame_start(frame_start)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Frame-level model: widths in force this frame, committed target, accepted shadow.
  int               cur [CH];
  int               tgt [CH];
  int               shd [CH];
  bit               pend;
  bit               xfer_prev;
  logic [CH*CW-1:0] cq [$];
  int               hi [CH];
  int               flen;
  int               nframes;
  int               off_bad;

  function automatic int map_us(input int c);
    return MIN_US + (c * (MAX_US - MIN_US)) / ((1 << CW) - 1);
  endfunction

  function automatic int step(input int c, input int t);
    if (!SLEW) return t;
    if (t > c) return (t - c > SLEW_US) ? c + SLEW_US : t;
    return (c - t > SLEW_US) ? c - SLEW_US : t;
  endfunction

  function automatic logic [CH*CW-1:0] rnd_cmd();
    logic [CH*CW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1));
    return r;
  endfunction

  // One clock: inputs set before the call were seen by the rising edge just passed.
  task automatic cyc();
    bit               was_rst;
    bit               ran;
    logic [CH*CW-1:0] c;
    was_rst = rst;
    ran     = enable && !rst;
    @(negedge clk);
    if (was_rst) begin
      pend = 1'b0; xfer_prev = 1'b0; flen = 0;
      for (int i = 0; i < CH; i++) begin cur[i] = CENTRE; tgt[i] = CENTRE; hi[i] = 0; end
      if (pwm != '0 || frame_start) off_bad++;
    end else if (!ran) begin
      flen = 0;
      for (int i = 0; i < CH; i++) hi[i] = 0;
      if (pwm != '0 || frame_start) off_bad++;
    end else begin
      flen++;
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm[i]);
      if (frame_start) begin
        chk("frame_len", flen, FRAME_CYC);
        for (int i = 0; i < CH; i++) chk($sformatf("pulse_ch%0d", i), hi[i], cur[i] * TDIV);
        if (pend) begin
          for (int i = 0; i < CH; i++) tgt[i] = shd[i];
          pend = 1'b0;
        end
        for (int i = 0; i < CH; i++) begin cur[i] = step(cur[i], tgt[i]); hi[i] = 0; end
        flen = 0;
        nframes++;
      end
    end
    if (xfer_prev) begin
      c = cq.pop_front();
      for (int i = 0; i < CH; i++) shd[i] = map_us(int'(c[i*CW +: CW]));
      pend      = 1'b1;
      xfer_prev = 1'b0;
      chk("rdy_after_xfer", int'(cmd_ready), 0);
    end else if (frame_start && ran) begin
      chk("rdy_at_frame", int'(cmd_ready), int'(!pend));
    end
    cmd_valid = (cq.size() != 0);
    cmd       = cmd_valid ? cq[0] : '0;
    xfer_prev = cmd_valid && cmd_ready && !rst;
  endtask

  task automatic run_frames(input int n);
    int target;
    int budget;
    target = nframes + n;
    budget = (n + 1) * FRAME_CYC;
    while (nframes < target && budget > 0) begin cyc(); budget--; end
    chk("frames_seen", nframes, target);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 3 * FRAME_CYC;
    while ((cq.size() != 0 || xfer_prev) && budget > 0) begin cyc(); budget--; end
    chk("xfer_done", cq.size() + int'(xfer_prev), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int budget;
    rst = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd = '0;
    pend = 1'b0; xfer_prev = 1'b0; flen = 0; nframes = 0; off_bad = 0;
    for (int i = 0; i < CH; i++) begin cur[i] = CENTRE; tgt[i] = CENTRE; shd[i] = CENTRE; hi[i] = 0; end

    // Reset state, then a centred first frame.
    idle(3);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_rdy", int'(cmd_ready), 1);
    chk("rst_quiet", off_bad, 0);
    rst = 1'b0;
    run_frames(1);

    // Full-scale and zero commands; visible one frame after acceptance.
    idle($urandom_range(10, 3000));
    cq.push_back(16'hFF00);
    run_frames(1);

    // Back-to-back sets: the second stalls across the boundary.
    idle($urandom_range(10, 3000));
    cq.push_back(16'h8080);
    cq.push_back(16'h0000);
    run_frames(3);

    // Random command, then drop enable mid-pulse with another accepted while idle.
    cq.push_back(rnd_cmd());
    run_frames(1);
    budget = 2 * FRAME_CYC;
    while (flen != 1400 && budget > 0) begin cyc(); budget--; end
    chk("reach_us700", flen, 1400);
    enable  = 1'b0;
    off_bad = 0;
    cyc();
    chk("dis_pwm", int'(pwm), 0);
    cq.push_back(rnd_cmd());
    idle(2000);
    chk("dis_quiet", off_bad, 0);
    chk("dis_rdy", int'(cmd_ready), 0);
    enable = 1'b1;
    run_frames(2);

    // Reset mid-frame with a command pending.
    cq.push_back(rnd_cmd());
    wait_idle();
    idle(500);
    chk("pre_rst_rdy", int'(cmd_ready), 0);
    off_bad = 0;
    rst = 1'b1;
    cyc();
    chk("rst2_rdy", int'(cmd_ready), 1);
    chk("rst2_pwm", int'(pwm), 0);
    cyc();
    rst = 1'b0;
    run_frames(1);
    chk("rst2_quiet", off_bad, 0);

    // Full-scale from centre: jump, or ramp when slewing.
    cq.push_back(16'hFFFF);
    run_frames(RAMP);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
